serial_sub_ctrl: RTL and testbench
==================================

# serial_sub_ctrl

Bit-serial subtraction controller that computes an N-bit difference with one `full_subtractor` cell, one bit per clock, LSB first. It holds the operands in shift registers and feeds the cell one bit at a time. The borrow is carried between bits in a flip-flop, and the difference bits are collected into a result register. It gives the lab datapath a multi-bit subtract with a start/done handshake at the cost of one cell and WIDTH+1 cycles.

## Interface
- `WIDTH`, default 8: operand/result width in bits, must be ≥ 2.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `start`  input  1  request; sampled only when `busy`=0.
- `a`  input  WIDTH  minuend; captured on the accepting edge.
- `b`  input  WIDTH  subtrahend; captured on the accepting edge.
- `bin`  input  1  initial borrow-in; captured on the accepting edge.
- `busy`  output  1  high while an operation is in progress (RUN state).
- `done`  output  1  one-cycle pulse; results valid in this cycle.
- `diff`  output  WIDTH  result a − b − bin mod 2^WIDTH.
- `bout`  output  1  final borrow-out (1 ⇔ a < b + bin, unsigned).
- `ov`  output  1  signed overflow; present only with `SERIAL_SUB_OV_EN`.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: `start`=1 → capture `a`, `b`, `bin`; clear bit counter; go to RUN.
  - RUN: each cycle, apply bit 0 of the `a`/`b` shift registers and the borrow FF to the cell.
    - Shift the cell's `Diff` into the MSB of the diff shift register; shift `a`/`b` right; load the borrow FF with `Bout`; increment the counter.
    - When the counter reaches WIDTH−1, go to DONE after this bit.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE. `start`=1 in DONE is accepted exactly as in IDLE: capture the operands and go straight to RUN (back-to-back operation).
- Results: `diff`/`bout`/`ov` are loaded on the edge that processes bit WIDTH−1. They hold until the edge that processes bit WIDTH−1 of the next operation. They never show partial results.
- `start` while `busy`=1 is ignored. Operand changes during RUN have no effect.
- Borrow chain is exact: bit i uses the borrow out of bit i−1; bit 0 uses the captured `bin`.
- Counter width is $clog2(WIDTH). It never wraps within an operation and is cleared on accept.
- Reset: any state → IDLE.
  - `busy`=0, `done`=0, `diff`=0, `bout`=0, `ov`=0.
  - Shift registers, borrow FF and counter are cleared.
  - Reset during RUN abandons the operation; no `done` pulse is produced for it.
  - `rst` has priority over `start` in the same cycle.

## Timing
- `start` high in cycle T (accepted) → `busy` high in cycles T+1 … T+WIDTH → `done` high in cycle T+WIDTH+1.
- Latency is WIDTH+1 cycles from the accepting edge to the `done` cycle.
- `diff`/`bout`/`ov` are valid from cycle T+WIDTH+1 onward.
- Throughput: one result per WIDTH+1 cycles when `start` is held or re-asserted in DONE.
- `busy` and `done` are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SERIAL_SUB_OV_EN` defined:
  - The `ov` port exists.
  - A second FF captures the borrow into the MSB (the borrow FF value when bit WIDTH−1 is applied).
  - `ov` = borrow-into-MSB XOR borrow-out-of-MSB, i.e. the two's-complement overflow of a − b − bin.
- Not defined: the `ov` port and its FF are absent; all other behaviour is identical.

## Structure
- Package `serial_sub_pkg`:
  - state enum `sub_state_t` {IDLE, RUN, DONE};
  - `SUB_WIDTH_DEFAULT` = 8.
- Sub-module: one existing `full_subtractor` instance is the datapath cell. The controller holds the shift registers, borrow FF, counter and FSM around it. No other sub-modules.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, bin=0, `start` in cycle T → `busy` in T+1…T+8; `done` in T+9 only; `diff`=0x1E, `bout`=0.
- a=0x00, b=0x01, bin=0 → `diff`=0xFF, `bout`=1. Then a=0x10, b=0x0F, bin=1 → `diff`=0x00, `bout`=0.
- With `SERIAL_SUB_OV_EN`:
  - a=0x80, b=0x01, bin=0 → `diff`=0x7F, `bout`=0, `ov`=1;
  - a=0x05, b=0x03 → `diff`=0x02, `ov`=0.
- Pulse `start` with a=0x01, b=0x01 in cycle T+3 of a running operation → ignored; the first result is unchanged; only one `done` pulse.
- Hold `start`=1 continuously with fixed operands → a `done` pulse every 9 cycles and `busy` low only in the `done` cycles.
- Assert `rst` in cycle T+4 of an operation → next cycle all outputs 0, state IDLE, no `done`. A fresh `start` then completes normally with the correct `diff`.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared types and defaults for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

    localparam int SUB_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module      : full_subtractor
// Description : One-bit full subtractor cell: Diff = A - B - Bin, Bout = borrow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    // Difference and borrow of a single bit position
    always_comb begin
        Diff = A ^ B ^ Bin;
        Bout = (~A & B) | (~(A ^ B) & Bin);
    end

endmodule

`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
// ============================================================================
// Module      : serial_sub_ctrl
// Description : Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, one
//               full_subtractor cell, start/busy/done handshake.
//               Optional macro SERIAL_SUB_OV_EN adds the signed overflow
//               output ov.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OV_EN
    ,
    output logic             ov
`endif
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    sub_state_t          r_state;
    sub_state_t          w_state_next;
    logic                w_accept;
    logic                w_last;

    logic [WIDTH-1:0]    r_a_sh;
    logic [WIDTH-1:0]    r_b_sh;
    logic [WIDTH-2:0]    r_diff_sh;   // difference bits collected so far
    logic                r_borrow;
    logic [c_cnt_w-1:0]  r_cnt;

    logic                r_busy;
    logic                r_done;
    logic [WIDTH-1:0]    r_diff;
    logic                r_bout;

    logic                w_cell_diff;
    logic                w_cell_bout;
    logic [WIDTH-1:0]    w_diff_full;

    full_subtractor u_cell (
        .A    (r_a_sh[0]),
        .B    (r_b_sh[0]),
        .Bin  (r_borrow),
        .Diff (w_cell_diff),
        .Bout (w_cell_bout)
    );

    // New bit enters at the MSB; after the last bit this is the full result
    assign w_diff_full = {w_cell_diff, r_diff_sh};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DONE accepts start exactly like IDLE for back-to-back ops
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = (r_cnt == c_cnt_last);
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand shifting, borrow chain, bit counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_diff_sh <= '0;
            r_borrow  <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_diff    <= '0;
            r_bout    <= 1'b0;
        end else begin
            r_busy <= (w_state_next == RUN);
            r_done <= (w_state_next == DONE);
            if (w_accept) begin
                r_a_sh    <= a;
                r_b_sh    <= b;
                r_borrow  <= bin;
                r_cnt     <= '0;
                r_diff_sh <= '0;
            end else if (r_state == RUN) begin
                r_a_sh    <= r_a_sh >> 1;
                r_b_sh    <= r_b_sh >> 1;
                r_borrow  <= w_cell_bout;
                r_diff_sh <= w_diff_full[WIDTH-1:1];
                if (w_last) begin
                    // Results change only here, so partial sums are never visible
                    r_diff <= w_diff_full;
                    r_bout <= w_cell_bout;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SERIAL_SUB_OV_EN
    logic r_msb_bin;
    logic r_ov;

    // Borrow into the MSB versus borrow out of it gives signed overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_msb_bin <= 1'b0;
            r_ov      <= 1'b0;
        end else if (!w_accept && r_state == RUN && w_last) begin
            r_msb_bin <= r_borrow;
            r_ov      <= r_borrow ^ w_cell_bout;
        end
    end

    assign ov = r_ov;
`else
    // Overflow tracking is absent in this build
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
// ============================================================================
// Module      : tb_serial_sub_ctrl
// Description : Self-checking bench for serial_sub_ctrl (WIDTH = 8).
//               Honours SERIAL_SUB_OV_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OV_EN
    logic         ov;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [W-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_ov;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OV_EN
        ,
        .ov    (ov)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        int u, s;
        u = int'(ma) - int'(mb) - int'(mbin);
        s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        exp_diff = W'(u);
        exp_bout = (u < 0);
        exp_ov   = (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
    endtask

    task automatic check_results(input string tag);
        check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        check({tag, "_bout"}, 32'(bout), 32'(exp_bout));
`ifdef SERIAL_SUB_OV_EN
        check({tag, "_ov"}, 32'(ov), 32'(exp_ov));
`endif
    endtask

    // One full operation; optionally pokes start with a=1,b=1 in cycle T+3
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                          input bit poke, input string tag);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; bin = tbin;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        for (int i = 1; i <= W; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check_results({tag, "_hold"});
            if (poke && i == 3) begin
                start = 1'b1; a = 1; b = 1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        model(ta, tb_, tbin);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check_results(tag);
        @(negedge clk);
        check({tag, "_after_done"}, 32'(done), 32'd0);
        check({tag, "_after_busy"}, 32'(busy), 32'd0);
        check_results({tag, "_after"});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        exp_diff = '0; exp_bout = 1'b0; exp_ov = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_results("rst");
        rst = 1'b0;

        // Directed cases
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "t5a3c");
        run_op(8'h00, 8'h01, 1'b0, 1'b0, "t0001");
        run_op(8'h10, 8'h0F, 1'b1, 1'b0, "t100f");
        run_op(8'h80, 8'h01, 1'b0, 1'b0, "t8001");
        run_op(8'h05, 8'h03, 1'b0, 1'b0, "t0503");
        run_op(8'h7F, 8'hFF, 1'b1, 1'b0, "t7fff");

        // Start during RUN must be ignored
        run_op(8'hC3, 8'h21, 1'b0, 1'b1, "ignore");

        // Back-to-back with start held: done every W+1 cycles
        @(negedge clk);
        start = 1'b1; a = 8'h9D; b = 8'hE4; bin = 1'b1;
        model(8'h9D, 8'hE4, 1'b1);
        for (int k = 1; k <= 3 * (W + 1); k++) begin
            @(negedge clk);
            if (k % (W + 1) == 0) begin
                check("b2b_done", 32'(done), 32'd1);
                check("b2b_busy_low", 32'(busy), 32'd0);
                check_results("b2b");
                if (k == 3 * (W + 1)) start = 1'b0;
            end else begin
                check("b2b_busy", 32'(busy), 32'd1);
                check("b2b_nodone", 32'(done), 32'd0);
            end
        end
        @(negedge clk);
        check("b2b_end_busy", 32'(busy), 32'd0);

        // Reset in cycle T+4 (with start also high) abandons the operation
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h44; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        exp_diff = '0; exp_bout = 1'b0; exp_ov = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check_results("mid_rst");
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            check("mid_rst_quiet_done", 32'(done), 32'd0);
            check("mid_rst_quiet_busy", 32'(busy), 32'd0);
        end
        run_op(8'h44, 8'h33, 1'b1, 1'b0, "post_rst");

        // Randomised operations with random idle gaps
        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
